// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default word width and occupancy-counter width helper.
// Imported by the FIFO top and its storage sub-module.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 140;

    // One extra bit so the counter can represent a completely full FIFO.
    function automatic int fifo_lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Purpose: DEPTH x DATA_W storage, one write port and one read port on one clock, no reset.
// Latency: write lands on the clock edge; read is combinational from the addressed entry.
// Backpressure: none here, the FIFO controller gates wr_vld.
module fifo_mem_2p
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              wr_vld,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_vld) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Purpose: single-clock FIFO with level, almost-full/empty and sticky over/underflow flags; FIFO_FWFT_EN selects first-word-fall-through output.
// Latency: status one edge after an accepted op; read data one edge after read (FWFT: head shown combinationally).
// Backpressure: writes refused while full, reads refused while empty; refused attempts set the sticky flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          fifo_flush,
    input  logic                          fifo_w_enable,
    input  logic [DATA_W-1:0]             data_to_fifo,
    input  logic                          fifo_r_enable,
    output logic [DATA_W-1:0]             data_from_fifo,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic                          fifo_almost_full,
    output logic                          fifo_almost_empty,
    output logic [fifo_lvl_w(DEPTH)-1:0]  fifo_level,
    output logic                          fifo_overflow,
    output logic                          fifo_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = fifo_lvl_w(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] head_dat;

    // Acceptance uses the flags as registered at the start of the cycle.
    assign fifo_empty        = (level_q == '0);
    assign fifo_full         = (level_q == LW'(DEPTH));
    assign fifo_almost_full  = (level_q >= LW'(AF_THRESH));
    assign fifo_almost_empty = (level_q <= LW'(AE_THRESH));
    assign fifo_level        = level_q;
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = unf_q;

    assign wr_acc = fifo_w_enable && !fifo_full  && !fifo_flush;
    assign rd_acc = fifo_r_enable && !fifo_empty && !fifo_flush;

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_in  (clk_in),
        .wr_vld  (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_dat  (data_to_fifo),
        .rd_addr (rd_ptr_q),
        .rd_dat  (head_dat)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            if (fifo_w_enable && fifo_full)  ovf_d = 1'b1;
            if (fifo_r_enable && fifo_empty) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head entry falls through; an empty FIFO presents zero rather than stale storage.
    assign data_from_fifo = fifo_empty ? '0 : head_dat;
`else
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = head_dat;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign data_from_fifo = dout_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DEPTH=8, DATA_W=140) with a queue-based reference model.
module tb_param_sync_fifo;

    localparam int DW    = 140;
    localparam int DEPTH = 8;
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 1;

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_flush = 1'b0;
    logic          fifo_w_enable = 1'b0;
    logic [DW-1:0] data_to_fifo = '0;
    logic          fifo_r_enable = 1'b0;
    logic [DW-1:0] data_from_fifo;
    logic          fifo_empty, fifo_full, fifo_almost_full, fifo_almost_empty;
    logic [3:0]    fifo_level;
    logic          fifo_overflow, fifo_underflow;

    int n_cmp = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    always #5 clk_in = ~clk_in;

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_in            (clk_in),
        .rst_n             (rst_n),
        .fifo_flush        (fifo_flush),
        .fifo_w_enable     (fifo_w_enable),
        .data_to_fifo      (data_to_fifo),
        .fifo_r_enable     (fifo_r_enable),
        .data_from_fifo    (data_from_fifo),
        .fifo_empty        (fifo_empty),
        .fifo_full         (fifo_full),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_level        (fifo_level),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    // Reference model: queue contents, sticky flags, last popped word.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [DW-1:0] m_dout = '0;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else if (fifo_flush) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            automatic bit was_full  = (mq.size() == DEPTH);
            automatic bit was_empty = (mq.size() == 0);
            if (fifo_w_enable && was_full)  m_ovf = 1'b1;
            if (fifo_r_enable && was_empty) m_unf = 1'b1;
            if (fifo_r_enable && !was_empty) m_dout = mq.pop_front();
            if (fifo_w_enable && !was_full)  mq.push_back(data_to_fifo);
        end
    end

    function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return (mq.size() == 0) ? '0 : mq[0];
`else
        return m_dout;
`endif
    endfunction

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (run_chk) begin
            automatic int lvl = mq.size();
            chk_d("model.dout",  data_from_fifo, exp_dout());
            chk_n("model.level", int'(fifo_level), lvl);
            chk_n("model.empty", int'(fifo_empty), int'(lvl == 0));
            chk_n("model.full",  int'(fifo_full), int'(lvl == DEPTH));
            chk_n("model.af",    int'(fifo_almost_full), int'(lvl >= AFT));
            chk_n("model.ae",    int'(fifo_almost_empty), int'(lvl <= AET));
            chk_n("model.ovf",   int'(fifo_overflow), int'(m_ovf));
            chk_n("model.unf",   int'(fifo_underflow), int'(m_unf));
        end
    end

    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
        fifo_w_enable = w;
        data_to_fifo  = d;
        fifo_r_enable = r;
        fifo_flush    = f;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk_in);
        #1;
        chk_n("rst.level", int'(fifo_level), 0);
        chk_n("rst.empty", int'(fifo_empty), 1);
        chk_n("rst.ae",    int'(fifo_almost_empty), 1);
        chk_n("rst.full",  int'(fifo_full), 0);
        chk_n("rst.af",    int'(fifo_almost_full), 0);
        chk_n("rst.ovf",   int'(fifo_overflow), 0);
        chk_n("rst.unf",   int'(fifo_underflow), 0);
        chk_d("rst.dout",  data_from_fifo, '0);
        rst_n   = 1'b1;
        run_chk = 1'b1;

`ifdef FIFO_FWFT_EN
        step(1, 'hA, 0, 0);
        chk_d("fwft.head", data_from_fifo, 'hA);
        step(0, 0, 1, 0);
        chk_d("fwft.zero", data_from_fifo, '0);
        chk_n("fwft.empty", int'(fifo_empty), 1);
`endif

        // Fill to full, then overflow
        for (int k = 1; k <= 8; k++) begin
            step(1, DW'(k), 0, 0);
            chk_n("fill.level", int'(fifo_level), k);
            chk_n("fill.af",    int'(fifo_almost_full), int'(k >= 6));
        end
        chk_n("fill.full", int'(fifo_full), 1);
        step(1, 'h99, 0, 0);
        chk_n("ovf.flag",  int'(fifo_overflow), 1);
        chk_n("ovf.level", int'(fifo_level), 8);

        // Drain in order, then underflow
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
            chk_d("drain.dout", data_from_fifo, DW'(k));
`endif
        end
        chk_n("drain.empty", int'(fifo_empty), 1);
        step(0, 0, 1, 0);
        chk_n("unf.flag", int'(fifo_underflow), 1);
`ifndef FIFO_FWFT_EN
        chk_d("unf.hold", data_from_fifo, 'h8);
`endif

        // Simultaneous read/write at full and at empty
        step(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) step(1, DW'('h10 + k), 0, 0);
        step(1, 'hEE, 1, 0);
        chk_n("fullrw.level", int'(fifo_level), 7);
`ifndef FIFO_FWFT_EN
        chk_d("fullrw.dout", data_from_fifo, 'h10);
`endif
        for (int k = 0; k < 7; k++) step(0, 0, 1, 0);
        step(1, 'h55, 1, 0);
        chk_n("emptyrw.level", int'(fifo_level), 1);
`ifndef FIFO_FWFT_EN
        chk_d("emptyrw.dout", data_from_fifo, 'h17);
`endif
        step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
        chk_d("emptyrw.read", data_from_fifo, 'h55);
`endif

        // Streaming at level 3 across pointer wrap
        for (int k = 0; k < 3; k++) step(1, DW'('h100 + k), 0, 0);
        for (int k = 0; k < 20; k++) begin
            step(1, DW'('h200 + k), 1, 0);
            chk_n("stream.level", int'(fifo_level), 3);
`ifndef FIFO_FWFT_EN
            chk_d("stream.dout", data_from_fifo, (k < 3) ? DW'('h100 + k) : DW'('h200 + k - 3));
`endif
        end
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0);

        // Flush with both sticky flags set at level 5
        step(0, 0, 1, 0);
        for (int k = 0; k < 8; k++) step(1, DW'('h30 + k), 0, 0);
        step(1, 'h77, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
        chk_n("preflush.level", int'(fifo_level), 5);
        chk_n("preflush.ovf",   int'(fifo_overflow), 1);
        chk_n("preflush.unf",   int'(fifo_underflow), 1);
        step(1, 'h88, 0, 1);
        chk_n("flush.level", int'(fifo_level), 0);
        chk_n("flush.empty", int'(fifo_empty), 1);
        chk_n("flush.ovf",   int'(fifo_overflow), 0);
        chk_n("flush.unf",   int'(fifo_underflow), 0);
`ifndef FIFO_FWFT_EN
        chk_d("flush.dout",  data_from_fifo, 'h32);
`endif
        step(0, 0, 0, 0);
        chk_n("flush.dropped", int'(fifo_level), 0);

        // Mixed traffic pattern
        for (int k = 0; k < 40; k++) step((k % 3) != 0, DW'('h400 + k), (k % 2) == 0, 0);

        // Reset asserted mid-stream while a write is pending
        fifo_w_enable = 1'b1;
        data_to_fifo  = 'hBAD;
        fifo_r_enable = 1'b1;
        #3 rst_n = 1'b0;
        @(posedge clk_in);
        #1;
        chk_n("midrst.level", int'(fifo_level), 0);
        chk_n("midrst.empty", int'(fifo_empty), 1);
        chk_d("midrst.dout",  data_from_fifo, '0);
        step(0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        chk_n("postrst.level", int'(fifo_level), 0);

        run_chk = 1'b0;
        @(posedge clk_in);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 140, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full level threshold.
REQ-004 SHALL have parameter AE_THRESH, default 1, almost-empty level threshold.
REQ-005 SHALL have ports in this order:
- clk_in  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_flush  input  1  synchronous clear of contents and sticky flags.
- fifo_w_enable  input  1  write request.
- data_to_fifo  input  DATA_W  write data.
- fifo_r_enable  input  1  read request.
- data_from_fifo  output  DATA_W  read data.
- fifo_empty  output  1  level == 0.
- fifo_full  output  1  level == DEPTH.
- fifo_almost_full  output  1  level >= AF_THRESH.
- fifo_almost_empty  output  1  level <= AE_THRESH.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.
- fifo_overflow  output  1  sticky: write attempted while full.
- fifo_underflow  output  1  sticky: read attempted while empty.

Function
REQ-006 SHALL accept a write iff fifo_w_enable && !fifo_full && !fifo_flush, storing data_to_fifo at the write pointer.
REQ-007 SHALL accept a read iff fifo_r_enable && !fifo_empty && !fifo_flush.
REQ-008 SHALL evaluate acceptance against flag values at the start of the cycle; when full with both requests, the read is accepted and the write rejected; when empty with both, the write is accepted and the read rejected.
REQ-009 SHALL update fifo_level by +1 (write only), -1 (read only) or 0 (both or neither), never leaving 0..DEPTH.
REQ-010 SHALL wrap read and write pointers modulo DEPTH, using a DEPTH-entry array.
REQ-011 SHALL derive every status output from registered state, reflecting an accepted operation in the cycle after the clock edge.
REQ-012 SHALL, without FIFO_FWFT_EN, load data_from_fifo with the head entry on the edge of an accepted read (latency 1) and hold it otherwise.
REQ-013 SHALL set fifo_overflow on any cycle with fifo_w_enable && fifo_full && !fifo_flush, and fifo_underflow likewise for fifo_r_enable && fifo_empty; both hold until flush or reset.
REQ-014 SHALL, on fifo_flush, zero pointers, level and sticky flags on that edge and take precedence over reads and writes in the same cycle; array contents and data_from_fifo are left unchanged.

Reset
REQ-015 SHALL on rst_n low asynchronously force pointers, fifo_level and data_from_fifo to 0, fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=(AF_THRESH==0), fifo_overflow=0, fifo_underflow=0.
REQ-016 SHALL not reset the storage array.
REQ-017 SHALL abandon any operation in progress when reset asserts mid-stream, with no write or read taking effect on that edge.

Configuration
REQ-018 SHALL, with FIFO_FWFT_EN defined, operate first-word-fall-through: data_from_fifo equals the head entry whenever !fifo_empty, equals 0 when empty, and an accepted read advances to the next entry with no added latency.
REQ-019 SHALL, without FIFO_FWFT_EN, behave per REQ-012.

Structure
REQ-020 SHALL take the default DATA_W (140) and the level-width calculation from the shared package fifo_pkg.
REQ-021 SHALL place storage in sub-module fifo_mem_2p (one write port, one read port, same clock, no reset).

Verification
REQ-022 Reset, then write 8 words 0x1..0x8 with DEPTH=8 -> fifo_full=1, fifo_level=8, almost_full high from level 6; a ninth write -> fifo_overflow=1, contents unchanged.
REQ-023 Read 8 times after REQ-022 -> data_from_fifo 0x1..0x8 in order, one cycle after each read (non-FWFT), fifo_empty=1; a ninth read -> fifo_underflow=1, data held at 0x8.
REQ-024 Full FIFO, both enables high for 1 cycle -> level 7, oldest word read, new word dropped; empty FIFO, both high -> level 1, no read.
REQ-025 Stream 20 words with continuous writes and reads at level 3 -> level stays 3, pointers wrap, output order is intact.
REQ-026 Level 5 with both sticky flags set, assert fifo_flush alongside fifo_w_enable -> next cycle level 0, empty=1, flags 0, write dropped.
REQ-027 FWFT build: write 0xA to an empty FIFO -> data_from_fifo=0xA the cycle after the write with no read issued; read -> returns to 0 and empty=1.
